// File: rtl/vga_pkg.sv
// vga_pkg -- shared types and constants for the video-memory write path.
//
// Contents:
//   fill_state_t    : rectangle-fill engine states (IDLE, FILL, DONE)
//   RES_*           : COLS/ROWS/nX/nY/Mn sets for the supported memory
//                     resolutions "160x120", "320x240" and "640x480"
//   DEF_*           : the default resolution (160x120)
package vga_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        DONE = 2'd2
    } fill_state_t;

    // "160x120"
    localparam int RES160_COLS = 160;
    localparam int RES160_ROWS = 120;
    localparam int RES160_NX   = 8;
    localparam int RES160_NY   = 7;
    localparam int RES160_MN   = 15;

    // "320x240"
    localparam int RES320_COLS = 320;
    localparam int RES320_ROWS = 240;
    localparam int RES320_NX   = 9;
    localparam int RES320_NY   = 8;
    localparam int RES320_MN   = 17;

    // "640x480"
    localparam int RES640_COLS = 640;
    localparam int RES640_ROWS = 480;
    localparam int RES640_NX   = 10;
    localparam int RES640_NY   = 9;
    localparam int RES640_MN   = 19;

    localparam int DEF_COLS = RES160_COLS;
    localparam int DEF_ROWS = RES160_ROWS;
    localparam int DEF_NX   = RES160_NX;
    localparam int DEF_NY   = RES160_NY;
    localparam int DEF_MN   = RES160_MN;

endpackage

// File: rtl/rect_scan_counter.sv
// rect_scan_counter -- nested column/row counter for a w x h rectangle scan.
//
// Ports:
//   clock   in   system clock
//   reset   in   synchronous, active-high
//   load    in   latch w/h and restart at (0,0)
//   step    in   advance one pixel in row-major order
//   w, h    in   rectangle size, sampled on load
//   next_i  out  column index the counter will hold after this edge
//   next_j  out  row index the counter will hold after this edge
//   last    out  current position is the final pixel (i==w-1 && j==h-1)
//
// next_i/next_j are exposed instead of the registered indices so that the
// parent can register its pixel outputs in the same edge the counter moves.
module rect_scan_counter #(
    parameter int IW = 9,
    parameter int JW = 8
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          load,
    input  logic          step,
    input  logic [IW-1:0] w,
    input  logic [JW-1:0] h,
    output logic [IW-1:0] next_i,
    output logic [JW-1:0] next_j,
    output logic          last
);

    logic [IW-1:0] i_r, w_r;
    logic [JW-1:0] j_r, h_r;
    logic          row_end;

    assign row_end = (i_r == w_r - IW'(1));
    assign last    = row_end && (j_r == h_r - JW'(1));

    // NOTE: every always_comb output gets a default first, so no path can
    // leave a value unassigned and infer a latch.
    always_comb begin
        next_i = i_r;
        next_j = j_r;
        if (load) begin
            next_i = '0;
            next_j = '0;
        end else if (step) begin
            if (row_end) begin
                next_i = '0;
                next_j = j_r + JW'(1);
            end else begin
                next_i = i_r + IW'(1);
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments only; blocking
    // assignments here would make results depend on process ordering.
    always_ff @(posedge clock) begin
        if (reset) begin
            i_r <= '0;
            j_r <= '0;
            w_r <= '0;
            h_r <= '0;
        end else begin
            i_r <= next_i;
            j_r <= next_j;
            if (load) begin
                w_r <= w;
                h_r <= h;
            end
        end
    end

endmodule

// File: rtl/vga_rect_filler.sv
// vga_rect_filler -- rectangle-fill write engine for the video memory.
//
// Accepts (x0,y0,w,h,color) over a valid/ready handshake and emits one pixel
// write per clock, row-major, at address = y*COLS + x (mod 2^Mn).
//
// Ports:
//   clock, reset         system clock, synchronous active-high reset
//   cmd_valid/cmd_ready  command handshake (ready only while IDLE)
//   cmd_x0, cmd_y0       rectangle top-left corner
//   cmd_w, cmd_h         rectangle size (zero allowed -> no writes)
//   cmd_color            fill color
//   mem_we               video memory write strobe
//   mem_address          write address
//   mem_color            write data
//   mem_x, mem_y         current pixel coordinates
//   busy                 high in FILL and DONE
//   done                 one-cycle pulse after the last pixel
//
// Build option: define VGA_RECT_FILLER_CLIP_EN to suppress writes whose
// full-width coordinates fall outside COLS x ROWS (scan timing unchanged).
module vga_rect_filler
    import vga_pkg::*;
#(
    parameter int COLOR_DEPTH = 3,
    parameter int nX          = DEF_NX,
    parameter int nY          = DEF_NY,
    parameter int Mn          = DEF_MN,
    parameter int COLS        = DEF_COLS,
    parameter int ROWS        = DEF_ROWS
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   cmd_valid,
    output logic                   cmd_ready,
    input  logic [nX-1:0]          cmd_x0,
    input  logic [nY-1:0]          cmd_y0,
    input  logic [nX:0]            cmd_w,
    input  logic [nY:0]            cmd_h,
    input  logic [COLOR_DEPTH-1:0] cmd_color,
    output logic                   mem_we,
    output logic [Mn-1:0]          mem_address,
    output logic [COLOR_DEPTH-1:0] mem_color,
    output logic [nX-1:0]          mem_x,
    output logic [nY-1:0]          mem_y,
    output logic                   busy,
    output logic                   done
);

    fill_state_t state, next_state;

    logic [nX-1:0]          x0_r;
    logic [nY-1:0]          y0_r;
    logic [COLOR_DEPTH-1:0] color_r;

    logic          load, step, last;
    logic [nX:0]   next_i;
    logic [nY:0]   next_j;

    rect_scan_counter #(.IW(nX + 1), .JW(nY + 1)) u_scan (
        .clock  (clock),
        .reset  (reset),
        .load   (load),
        .step   (step),
        .w      (cmd_w),
        .h      (cmd_h),
        .next_i (next_i),
        .next_j (next_j),
        .last   (last)
    );

    assign cmd_ready = (state == IDLE);

    always_comb begin
        next_state = state;
        load       = 1'b0;
        step       = 1'b0;
        unique case (state)
            IDLE: if (cmd_valid) begin
                load       = 1'b1;
                next_state = (cmd_w != '0 && cmd_h != '0) ? FILL : DONE;
            end
            FILL: if (last) next_state = DONE;
                  else      step       = 1'b1;
            DONE: next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // The pixel registered at this edge is the one the counter moves to, so
    // on the accept edge the base must come straight from the command port.
    logic [nX-1:0]          base_x;
    logic [nY-1:0]          base_y;
    logic [COLOR_DEPTH-1:0] pix_color;
    logic [nX:0]            x_sum;
    logic [nY:0]            y_sum;
    logic [Mn-1:0]          pix_address;
    logic                   pix_we;

    always_comb begin
        base_x      = load ? cmd_x0    : x0_r;
        base_y      = load ? cmd_y0    : y0_r;
        pix_color   = load ? cmd_color : color_r;
        x_sum       = {1'b0, base_x} + next_i;
        y_sum       = {1'b0, base_y} + next_j;
        pix_address = Mn'(y_sum[nY-1:0]) * Mn'(COLS) + Mn'(x_sum[nX-1:0]);
`ifdef VGA_RECT_FILLER_CLIP_EN
        pix_we      = (int'(x_sum) < COLS) && (int'(y_sum) < ROWS);
`else
        pix_we      = 1'b1;
`endif
    end

    always_ff @(posedge clock) begin
        if (reset) state <= IDLE;
        else       state <= next_state;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            x0_r        <= '0;
            y0_r        <= '0;
            color_r     <= '0;
            mem_we      <= 1'b0;
            mem_address <= '0;
            mem_color   <= '0;
            mem_x       <= '0;
            mem_y       <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
        end else begin
            if (load) begin
                x0_r    <= cmd_x0;
                y0_r    <= cmd_y0;
                color_r <= cmd_color;
            end
            busy   <= (next_state != IDLE);
            done   <= (next_state == DONE);
            mem_we <= (next_state == FILL) && pix_we;
            // Pixel bus holds its last value whenever no write is issued.
            if (next_state == FILL && pix_we) begin
                mem_address <= pix_address;
                mem_color   <= pix_color;
                mem_x       <= x_sum[nX-1:0];
                mem_y       <= y_sum[nY-1:0];
            end
        end
    end

endmodule

// File: tb/tb_vga_rect_filler.sv
// tb_vga_rect_filler -- self-checking bench for vga_rect_filler (160x120).
// Each command is compared slot by slot against a reference built from the
// rectangle definition: pixel k sits at (x0 + k%w, y0 + k/w).
module tb_vga_rect_filler;

    localparam int COLS = 160;
    localparam int ROWS = 120;

    logic       clock = 1'b0;
    logic       reset;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [7:0] cmd_x0;
    logic [6:0] cmd_y0;
    logic [8:0] cmd_w;
    logic [7:0] cmd_h;
    logic [2:0] cmd_color;
    logic       mem_we;
    logic [14:0] mem_address;
    logic [2:0] mem_color;
    logic [7:0] mem_x;
    logic [6:0] mem_y;
    logic       busy;
    logic       done;

    int n_checks = 0;
    int n_pass   = 0;

    vga_rect_filler dut (
        .clock       (clock),
        .reset       (reset),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_x0      (cmd_x0),
        .cmd_y0      (cmd_y0),
        .cmd_w       (cmd_w),
        .cmd_h       (cmd_h),
        .cmd_color   (cmd_color),
        .mem_we      (mem_we),
        .mem_address (mem_address),
        .mem_color   (mem_color),
        .mem_x       (mem_x),
        .mem_y       (mem_y),
        .busy        (busy),
        .done        (done)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    endtask

    // Issue one command at the current negedge (engine must be idle) and
    // check every slot, the done cycle and the return to idle. Returns at
    // the negedge of the first idle cycle. With hold set, cmd_valid stays
    // high with the same fields so an early re-accept would be exposed.
    task automatic run_cmd(input int x0, input int y0, input int w, input int h,
                           input int color, input bit hold, input string name);
        int slots;
        int x, y, exp_addr;
        bit exp_we;
        cmd_valid = 1'b1;
        cmd_x0    = 8'(x0);
        cmd_y0    = 7'(y0);
        cmd_w     = 9'(w);
        cmd_h     = 8'(h);
        cmd_color = 3'(color);
        check({name, ":ready_at_issue"}, 32'(cmd_ready), 1);
        check({name, ":idle_not_busy"}, 32'(busy), 0);
        @(posedge clock);
        @(negedge clock);
        if (!hold) cmd_valid = 1'b0;
        slots = w * h;
        for (int k = 0; k < slots; k++) begin
            x = x0 + k % w;
            y = y0 + k / w;
`ifdef VGA_RECT_FILLER_CLIP_EN
            exp_we = (x < COLS) && (y < ROWS);
`else
            exp_we = 1'b1;
`endif
            exp_addr = ((y % 128) * COLS + (x % 256)) % 32768;
            check({name, ":we"}, 32'(mem_we), 32'(exp_we));
            check({name, ":ready_fill"}, 32'(cmd_ready), 0);
            check({name, ":busy_fill"}, 32'(busy), 1);
            check({name, ":done_fill"}, 32'(done), 0);
            if (exp_we) begin
                check({name, ":addr"},  32'(mem_address), 32'(exp_addr));
                check({name, ":x"},     32'(mem_x), 32'(x % 256));
                check({name, ":y"},     32'(mem_y), 32'(y % 128));
                check({name, ":color"}, 32'(mem_color), 32'(color));
            end
            @(negedge clock);
        end
        check({name, ":done_pulse"}, 32'(done), 1);
        check({name, ":we_in_done"}, 32'(mem_we), 0);
        check({name, ":busy_done"}, 32'(busy), 1);
        check({name, ":ready_done"}, 32'(cmd_ready), 0);
        @(negedge clock);
        check({name, ":done_cleared"}, 32'(done), 0);
        check({name, ":busy_idle"}, 32'(busy), 0);
        check({name, ":ready_idle"}, 32'(cmd_ready), 1);
        check({name, ":we_idle"}, 32'(mem_we), 0);
    endtask

    initial begin
        #10_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int x0, y0, w, h;
        bit hold;
        reset     = 1'b1;
        cmd_valid = 1'b1;          // must be ignored while in reset
        cmd_x0    = 8'd3;
        cmd_y0    = 7'd3;
        cmd_w     = 9'd2;
        cmd_h     = 8'd2;
        cmd_color = 3'd7;
        repeat (3) @(negedge clock);
        check("rst:we",    32'(mem_we), 0);
        check("rst:busy",  32'(busy), 0);
        check("rst:done",  32'(done), 0);
        check("rst:addr",  32'(mem_address), 0);
        check("rst:x",     32'(mem_x), 0);
        check("rst:y",     32'(mem_y), 0);
        check("rst:color", 32'(mem_color), 0);
        cmd_valid = 1'b0;
        reset     = 1'b0;
        check("rst:ready", 32'(cmd_ready), 1);
        @(negedge clock);
        check("post_rst:busy", 32'(busy), 0);

        // Reset in the middle of a 10x10 fill aborts without a done pulse.
        cmd_valid = 1'b1;
        cmd_x0 = 8'd0; cmd_y0 = 7'd0; cmd_w = 9'd10; cmd_h = 8'd10; cmd_color = 3'd6;
        @(posedge clock);
        @(negedge clock);
        cmd_valid = 1'b0;
        check("abort:we_before", 32'(mem_we), 1);
        repeat (4) @(negedge clock);
        reset = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(posedge clock);
            #1;
            check("abort:we",   32'(mem_we), 0);
            check("abort:done", 32'(done), 0);
            check("abort:busy", 32'(busy), 0);
        end
        @(negedge clock);
        reset = 1'b0;
        check("abort:ready", 32'(cmd_ready), 1);
        repeat (2) @(negedge clock);
        check("abort:no_done", 32'(done), 0);
        check("abort:idle_we", 32'(mem_we), 0);

        // Directed cases.
        run_cmd(5, 2, 3, 2, 3'b101, 1'b0, "small");
        run_cmd(7, 9, 0, 4, 2, 1'b0, "w0");
        run_cmd(7, 9, 4, 0, 2, 1'b0, "h0");
        run_cmd(158, 118, 4, 3, 4, 1'b0, "edge");
        run_cmd(0, 0, 160, 120, 1, 1'b0, "full");
        // Back-to-back with cmd_valid held high throughout.
        run_cmd(20, 30, 3, 3, 5, 1'b1, "queue_a");
        run_cmd(40, 50, 2, 2, 6, 1'b0, "queue_b");

        // Randomized commands, some held back-to-back, some near edges.
        for (int n = 0; n < 30; n++) begin
            x0   = ($urandom_range(0, 3) == 0) ? int'($urandom_range(140, 255)) : int'($urandom_range(0, 159));
            y0   = ($urandom_range(0, 3) == 0) ? int'($urandom_range(100, 127)) : int'($urandom_range(0, 119));
            w    = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 12));
            h    = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 6));
            hold = ($urandom_range(0, 1) == 1) && (n != 29);
            run_cmd(x0, y0, w, h, int'($urandom_range(0, 7)), hold, "rand");
            if (!hold && $urandom_range(0, 1) == 1) begin
                @(negedge clock);
                check("rand:gap_idle", 32'(busy), 0);
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
